// File: rtl/rs_cdb_wakeup_bank_pkg.sv
// Shared defaults and operand-state helpers for the CDB wakeup reservation-station bank.
package rs_cdb_wakeup_bank_pkg;

  localparam int unsigned RS_DEPTH_DEF  = 4;
  localparam int unsigned TAG_W_DEF     = 3;
  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned PAYLOAD_W_DEF = 32;

  // Per-operand status relative to the current CDB broadcast.
  typedef enum logic [1:0] {
    OPND_HELD    = 2'd0,
    OPND_CDB_NOW = 2'd1,
    OPND_WAIT    = 2'd2
  } opnd_state_e;

  function automatic int unsigned age_width(input int unsigned depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-first arbiter: grants the requesting entry with the highest age.
module rs_age_select
  import rs_cdb_wakeup_bank_pkg::*;
#(
  parameter int unsigned RS_DEPTH = RS_DEPTH_DEF,
  parameter int unsigned AGE_W    = age_width(RS_DEPTH_DEF)
) (
  input  logic [RS_DEPTH-1:0]            req,
  input  logic [RS_DEPTH-1:0][AGE_W-1:0] age,
  output logic [RS_DEPTH-1:0]            grant,
  output logic                           any
);

  // Ages of valid entries are distinct, so at most one requester survives.
  always_comb begin
    grant = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (j != i && req[j] && (age[j] > age[i])) begin
          grant[i] = 1'b0;
        end
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rs_cdb_wakeup_bank.sv
// Reservation-station bank: captures CDB results by tag, issues oldest ready entry.
// Optional CDB_ISSUE_BYPASS_EN lets an entry issue in the same cycle its last operand is broadcast.
module rs_cdb_wakeup_bank
  import rs_cdb_wakeup_bank_pkg::*;
#(
  parameter int unsigned RS_DEPTH  = RS_DEPTH_DEF,
  parameter int unsigned TAG_W     = TAG_W_DEF,
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  logic                 dispatch_valid,
  output logic                 dispatch_ready,
  input  logic [TAG_W-1:0]     dispatch_dest_tag,
  input  logic                 dispatch_rs1_rdy,
  input  logic [TAG_W-1:0]     dispatch_rs1_tag,
  input  logic [XLEN-1:0]      dispatch_rs1_val,
  input  logic                 dispatch_rs2_rdy,
  input  logic [TAG_W-1:0]     dispatch_rs2_tag,
  input  logic [XLEN-1:0]      dispatch_rs2_val,
  input  logic [PAYLOAD_W-1:0] dispatch_payload,
  input  logic                 cdb_valid,
  input  logic [TAG_W-1:0]     cdb_tag,
  input  logic [XLEN-1:0]      cdb_value,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [TAG_W-1:0]     issue_dest_tag,
  output logic [XLEN-1:0]      issue_rs1_val,
  output logic [XLEN-1:0]      issue_rs2_val,
  output logic [PAYLOAD_W-1:0] issue_payload
);

  localparam int unsigned AGE_W = age_width(RS_DEPTH);

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     dest_tag;
    logic                 rs1_rdy;
    logic [TAG_W-1:0]     rs1_tag;
    logic [XLEN-1:0]      rs1_val;
    logic                 rs2_rdy;
    logic [TAG_W-1:0]     rs2_tag;
    logic [XLEN-1:0]      rs2_val;
    logic [PAYLOAD_W-1:0] payload;
    logic [AGE_W-1:0]     age;
  } rs_entry_t;

  rs_entry_t ent [RS_DEPTH];

  logic [RS_DEPTH-1:0]            valid_vec;
  logic [RS_DEPTH-1:0][AGE_W-1:0] age_vec;
  logic [RS_DEPTH-1:0]            req;
  logic [RS_DEPTH-1:0]            grant;
  logic [RS_DEPTH-1:0]            age_used;
  opnd_state_e                    s1 [RS_DEPTH];
  opnd_state_e                    s2 [RS_DEPTH];
  opnd_state_e                    d1;
  opnd_state_e                    d2;
  logic [AGE_W-1:0]               free_idx;
  logic [AGE_W-1:0]               age_hole;
  logic                           sel_any;
  logic                           full;
  logic                           dispatch_fire;
  logic                           issue_fire;

  function automatic opnd_state_e opnd_state(input logic             rdy,
                                             input logic [TAG_W-1:0] tag,
                                             input logic             bus_valid,
                                             input logic [TAG_W-1:0] bus_tag);
    if (rdy) return OPND_HELD;
    if (bus_valid && (bus_tag == tag)) return OPND_CDB_NOW;
    return OPND_WAIT;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      valid_vec[i] = ent[i].valid;
      age_vec[i]   = ent[i].age;
      s1[i]        = opnd_state(ent[i].rs1_rdy, ent[i].rs1_tag, cdb_valid, cdb_tag);
      s2[i]        = opnd_state(ent[i].rs2_rdy, ent[i].rs2_tag, cdb_valid, cdb_tag);
`ifdef CDB_ISSUE_BYPASS_EN
      req[i]       = ent[i].valid && (s1[i] != OPND_WAIT) && (s2[i] != OPND_WAIT);
`else
      req[i]       = ent[i].valid && ent[i].rs1_rdy && ent[i].rs2_rdy;
`endif
    end
  end

  assign d1 = opnd_state(dispatch_rs1_rdy, dispatch_rs1_tag, cdb_valid, cdb_tag);
  assign d2 = opnd_state(dispatch_rs2_rdy, dispatch_rs2_tag, cdb_valid, cdb_tag);

  // Lowest free slot, and the lowest age value not held by any valid entry.
  always_comb begin
    free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid_vec[i]) free_idx = AGE_W'(i);
    end
    age_used = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (valid_vec[i]) age_used[age_vec[i]] = 1'b1;
    end
    age_hole = '0;
    for (int h = RS_DEPTH - 1; h >= 0; h--) begin
      if (!age_used[h]) age_hole = AGE_W'(h);
    end
  end

  rs_age_select #(
    .RS_DEPTH (RS_DEPTH),
    .AGE_W    (AGE_W)
  ) u_age_select (
    .req   (req),
    .age   (age_vec),
    .grant (grant),
    .any   (sel_any)
  );

  assign full           = &valid_vec;
  assign dispatch_ready = !reset && !squash && !full;
  assign issue_valid    = !reset && !squash && sel_any;
  assign dispatch_fire  = dispatch_valid && dispatch_ready;
  assign issue_fire     = issue_valid && issue_ready;

  always_comb begin
    issue_dest_tag = '0;
    issue_rs1_val  = '0;
    issue_rs2_val  = '0;
    issue_payload  = '0;
    if (issue_valid) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (grant[i]) begin
          issue_dest_tag = ent[i].dest_tag;
          issue_payload  = ent[i].payload;
`ifdef CDB_ISSUE_BYPASS_EN
          issue_rs1_val  = (s1[i] == OPND_CDB_NOW) ? cdb_value : ent[i].rs1_val;
          issue_rs2_val  = (s2[i] == OPND_CDB_NOW) ? cdb_value : ent[i].rs2_val;
`else
          issue_rs1_val  = ent[i].rs1_val;
          issue_rs2_val  = ent[i].rs2_val;
`endif
        end
      end
    end
  end

  // Operand data is qualified by valid, so only valid and age take reset.
  // On dispatch, entries below the age hole shift up by one: order is kept
  // and ages stay distinct within 0..RS_DEPTH-1 even after out-of-order issue.
  always_ff @(posedge clock) begin
    if (!squash) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (ent[i].valid) begin
          if (s1[i] == OPND_CDB_NOW) begin
            ent[i].rs1_rdy <= 1'b1;
            ent[i].rs1_val <= cdb_value;
          end
          if (s2[i] == OPND_CDB_NOW) begin
            ent[i].rs2_rdy <= 1'b1;
            ent[i].rs2_val <= cdb_value;
          end
        end
      end
    end
    if (dispatch_fire) begin
      ent[free_idx].dest_tag <= dispatch_dest_tag;
      ent[free_idx].rs1_rdy  <= (d1 != OPND_WAIT);
      ent[free_idx].rs1_tag  <= dispatch_rs1_tag;
      ent[free_idx].rs1_val  <= (d1 == OPND_CDB_NOW) ? cdb_value : dispatch_rs1_val;
      ent[free_idx].rs2_rdy  <= (d2 != OPND_WAIT);
      ent[free_idx].rs2_tag  <= dispatch_rs2_tag;
      ent[free_idx].rs2_val  <= (d2 == OPND_CDB_NOW) ? cdb_value : dispatch_rs2_val;
      ent[free_idx].payload  <= dispatch_payload;
    end
    if (reset) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].age   <= '0;
      end
    end else if (squash) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (issue_fire && grant[i]) begin
          ent[i].valid <= 1'b0;
        end
        if (dispatch_fire && ent[i].valid && (ent[i].age < age_hole)) begin
          ent[i].age <= ent[i].age + 1'b1;
        end
      end
      if (dispatch_fire) begin
        ent[free_idx].valid <= 1'b1;
        ent[free_idx].age   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rs_cdb_wakeup_bank.sv
// Bench for rs_cdb_wakeup_bank: directed vector table, then random traffic against a queue model.
module tb_rs_cdb_wakeup_bank;

  localparam int DEPTH = 4;
`ifdef CDB_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, squash, dispatch_valid, dispatch_ready;
  logic [2:0]  dispatch_dest_tag, dispatch_rs1_tag, dispatch_rs2_tag;
  logic        dispatch_rs1_rdy, dispatch_rs2_rdy;
  logic [31:0] dispatch_rs1_val, dispatch_rs2_val, dispatch_payload;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        issue_valid, issue_ready;
  logic [2:0]  issue_dest_tag;
  logic [31:0] issue_rs1_val, issue_rs2_val, issue_payload;

  always #5 clock = ~clock;

  rs_cdb_wakeup_bank #(
    .RS_DEPTH (DEPTH), .TAG_W (3), .XLEN (32), .PAYLOAD_W (32)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .squash            (squash),
    .dispatch_valid    (dispatch_valid),
    .dispatch_ready    (dispatch_ready),
    .dispatch_dest_tag (dispatch_dest_tag),
    .dispatch_rs1_rdy  (dispatch_rs1_rdy),
    .dispatch_rs1_tag  (dispatch_rs1_tag),
    .dispatch_rs1_val  (dispatch_rs1_val),
    .dispatch_rs2_rdy  (dispatch_rs2_rdy),
    .dispatch_rs2_tag  (dispatch_rs2_tag),
    .dispatch_rs2_val  (dispatch_rs2_val),
    .dispatch_payload  (dispatch_payload),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .cdb_value         (cdb_value),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_dest_tag    (issue_dest_tag),
    .issue_rs1_val     (issue_rs1_val),
    .issue_rs2_val     (issue_rs2_val),
    .issue_payload     (issue_payload)
  );

  typedef struct {
    logic rst, sq, dv; logic [2:0] dtag;
    logic r1rdy; logic [2:0] r1tag; logic [31:0] r1val;
    logic r2rdy; logic [2:0] r2tag; logic [31:0] r2val;
    logic [31:0] pl;
    logic cv; logic [2:0] ctag; logic [31:0] cval;
    logic ir;
    logic e_dr, e_iv; logic [2:0] e_tag; logic [31:0] e_v1, e_v2, e_pl;
  } vec_t;

  // Model entry; queue order is dispatch order, front is oldest.
  typedef struct {
    logic [2:0] dest;
    logic r1; logic [2:0] t1; logic [31:0] v1;
    logic r2; logic [2:0] t2; logic [31:0] v2;
    logic [31:0] pl;
  } ment_t;

  ment_t mq[$];
  vec_t  tbl[$];
  int    checks = 0;
  int    failures = 0;

  function automatic vec_t blank();
    vec_t v;
    v.rst = 0; v.sq = 0; v.dv = 0; v.dtag = 0;
    v.r1rdy = 0; v.r1tag = 0; v.r1val = 0;
    v.r2rdy = 0; v.r2tag = 0; v.r2val = 0; v.pl = 0;
    v.cv = 0; v.ctag = 0; v.cval = 0; v.ir = 0;
    v.e_dr = 1; v.e_iv = 0; v.e_tag = 0; v.e_v1 = 0; v.e_v2 = 0; v.e_pl = 0;
    return v;
  endfunction

  function automatic vec_t expect_issue(input vec_t v, input logic [2:0] t,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] p);
    vec_t r = v;
    r.e_iv = 1; r.e_tag = t; r.e_v1 = a; r.e_v2 = b; r.e_pl = p;
    return r;
  endfunction

  task automatic apply(input vec_t v);
    reset = v.rst; squash = v.sq; dispatch_valid = v.dv; dispatch_dest_tag = v.dtag;
    dispatch_rs1_rdy = v.r1rdy; dispatch_rs1_tag = v.r1tag; dispatch_rs1_val = v.r1val;
    dispatch_rs2_rdy = v.r2rdy; dispatch_rs2_tag = v.r2tag; dispatch_rs2_val = v.r2val;
    dispatch_payload = v.pl; cdb_valid = v.cv; cdb_tag = v.ctag; cdb_value = v.cval;
    issue_ready = v.ir;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string p, input logic e_dr, input logic e_iv,
                               input logic [2:0] e_tag, input logic [31:0] e_v1,
                               input logic [31:0] e_v2, input logic [31:0] e_pl);
    chk({p, ".dispatch_ready"}, 32'(dispatch_ready), 32'(e_dr));
    chk({p, ".issue_valid"},    32'(issue_valid),    32'(e_iv));
    chk({p, ".issue_dest_tag"}, 32'(issue_dest_tag), 32'(e_tag));
    chk({p, ".issue_rs1_val"},  issue_rs1_val,       e_v1);
    chk({p, ".issue_rs2_val"},  issue_rs2_val,       e_v2);
    chk({p, ".issue_payload"},  issue_payload,       e_pl);
  endtask

  function automatic logic op_rdy(input logic r, input logic [2:0] t);
    return r || (BYP && cdb_valid && (cdb_tag == t));
  endfunction

  function automatic int model_pick();
    if (reset || squash) return -1;
    for (int k = 0; k < mq.size(); k++) begin
      if (op_rdy(mq[k].r1, mq[k].t1) && op_rdy(mq[k].r2, mq[k].t2)) return k;
    end
    return -1;
  endfunction

  task automatic check_model(input string p);
    int k;
    logic dr, iv;
    logic [2:0] t;
    logic [31:0] a, b, pl;
    dr = !reset && !squash && (mq.size() < DEPTH);
    k = model_pick();
    iv = (k >= 0);
    t = 0; a = 0; b = 0; pl = 0;
    if (iv) begin
      t  = mq[k].dest;
      a  = mq[k].r1 ? mq[k].v1 : cdb_value;
      b  = mq[k].r2 ? mq[k].v2 : cdb_value;
      pl = mq[k].pl;
    end
    check_outputs(p, dr, iv, t, a, b, pl);
  endtask

  // Applies one clock edge to the model using the inputs held during the cycle.
  task automatic model_update();
    int k;
    bit dfire;
    ment_t n;
    if (reset || squash) begin
      mq.delete();
      return;
    end
    k = model_pick();
    if (!issue_ready) k = -1;
    dfire = dispatch_valid && (mq.size() < DEPTH);
    if (cdb_valid) begin
      for (int j = 0; j < mq.size(); j++) begin
        if (!mq[j].r1 && mq[j].t1 == cdb_tag) begin mq[j].r1 = 1; mq[j].v1 = cdb_value; end
        if (!mq[j].r2 && mq[j].t2 == cdb_tag) begin mq[j].r2 = 1; mq[j].v2 = cdb_value; end
      end
    end
    if (k >= 0) mq.delete(k);
    if (dfire) begin
      n.dest = dispatch_dest_tag;
      n.t1 = dispatch_rs1_tag;
      n.r1 = dispatch_rs1_rdy || (cdb_valid && cdb_tag == dispatch_rs1_tag);
      n.v1 = dispatch_rs1_rdy ? dispatch_rs1_val : cdb_value;
      n.t2 = dispatch_rs2_tag;
      n.r2 = dispatch_rs2_rdy || (cdb_valid && cdb_tag == dispatch_rs2_tag);
      n.v2 = dispatch_rs2_rdy ? dispatch_rs2_val : cdb_value;
      n.pl = dispatch_payload;
      mq.push_back(n);
    end
  endtask

  task automatic build_table();
    vec_t v;
    // Reset held two cycles with dispatch offered, then released.
    v = blank(); v.rst = 1; v.dv = 1; v.dtag = 2; v.r1rdy = 1; v.r2rdy = 1; v.e_dr = 0;
    tbl.push_back(v); tbl.push_back(v);
    tbl.push_back(blank());
    // Both operands ready at dispatch.
    v = blank(); v.dv = 1; v.dtag = 3; v.r1rdy = 1; v.r1val = 5; v.r2rdy = 1; v.r2val = 7;
    v.pl = 32'hA5A5; tbl.push_back(v);
    tbl.push_back(expect_issue(blank(), 3, 5, 7, 32'hA5A5));
    v = blank(); v.ir = 1; tbl.push_back(expect_issue(v, 3, 5, 7, 32'hA5A5));
    tbl.push_back(blank());
    // rs1 waits on tag 2, broadcast two cycles after dispatch.
    v = blank(); v.dv = 1; v.dtag = 1; v.r1tag = 2; v.r2rdy = 1; v.r2val = 32'h22;
    v.pl = 32'h11; tbl.push_back(v);
    tbl.push_back(blank());
    v = blank(); v.cv = 1; v.ctag = 2; v.cval = 32'h1234;
    tbl.push_back(BYP ? expect_issue(v, 1, 32'h1234, 32'h22, 32'h11) : v);
    v = blank(); v.ir = 1; tbl.push_back(expect_issue(v, 1, 32'h1234, 32'h22, 32'h11));
    tbl.push_back(blank());
    // Both operands captured from the broadcast seen at dispatch.
    v = blank(); v.dv = 1; v.dtag = 4; v.r1tag = 6; v.r2tag = 6; v.pl = 32'h44;
    v.cv = 1; v.ctag = 6; v.cval = 9; tbl.push_back(v);
    v = blank(); v.ir = 1; tbl.push_back(expect_issue(v, 4, 9, 9, 32'h44));
    tbl.push_back(blank());
    // Fill four entries, wake 3 then 1, oldest (1) issues first.
    for (int k = 0; k < 4; k++) begin
      v = blank(); v.dv = 1; v.dtag = 3'(k); v.r1tag = 3'(k + 4); v.r2rdy = 1;
      v.r2val = k; v.pl = 32'h100 + k; tbl.push_back(v);
    end
    v = blank(); v.dv = 1; v.dtag = 5; v.r1rdy = 1; v.r2rdy = 1; v.e_dr = 0; tbl.push_back(v);
    v = blank(); v.cv = 1; v.ctag = 7; v.cval = 32'h33; v.e_dr = 0;
    tbl.push_back(BYP ? expect_issue(v, 3, 32'h33, 3, 32'h103) : v);
    v = blank(); v.cv = 1; v.ctag = 5; v.cval = 32'h11; v.e_dr = 0;
    tbl.push_back(BYP ? expect_issue(v, 1, 32'h11, 1, 32'h101)
                      : expect_issue(v, 3, 32'h33, 3, 32'h103));
    v = blank(); v.ir = 1; v.e_dr = 0; tbl.push_back(expect_issue(v, 1, 32'h11, 1, 32'h101));
    tbl.push_back(expect_issue(blank(), 3, 32'h33, 3, 32'h103));
    v = blank(); v.ir = 1; tbl.push_back(expect_issue(v, 3, 32'h33, 3, 32'h103));
    tbl.push_back(blank());
    // Third entry ready, then squash with both handshakes offered.
    v = blank(); v.dv = 1; v.dtag = 5; v.r1rdy = 1; v.r1val = 32'h55; v.r2rdy = 1;
    v.r2val = 32'h66; v.pl = 32'h500; tbl.push_back(v);
    v = blank(); v.sq = 1; v.dv = 1; v.dtag = 6; v.r1rdy = 1; v.r2rdy = 1; v.ir = 1;
    v.e_dr = 0; tbl.push_back(v);
    v = blank(); v.ir = 1; tbl.push_back(v);
    v = blank(); v.ir = 1; v.cv = 1; v.ctag = 4; v.cval = 32'h77; tbl.push_back(v);
    v = blank(); v.ir = 1; v.cv = 1; v.ctag = 6; v.cval = 32'h78; tbl.push_back(v);
  endtask

  initial begin
    vec_t v;
    apply(blank());
    build_table();
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #2;
      check_outputs($sformatf("vec%0d", i), tbl[i].e_dr, tbl[i].e_iv, tbl[i].e_tag,
                    tbl[i].e_v1, tbl[i].e_v2, tbl[i].e_pl);
      @(posedge clock);
      model_update();
      #1;
    end
    for (int c = 0; c < 800; c++) begin
      v = blank();
      v.rst   = ($urandom_range(0, 59) == 0);
      v.sq    = ($urandom_range(0, 29) == 0);
      v.dv    = $urandom_range(0, 1);
      v.dtag  = 3'($urandom_range(0, 7));
      v.r1rdy = $urandom_range(0, 1);
      v.r1tag = 3'($urandom_range(0, 7));
      v.r1val = $urandom;
      v.r2rdy = $urandom_range(0, 1);
      v.r2tag = 3'($urandom_range(0, 7));
      v.r2val = $urandom;
      v.pl    = $urandom;
      v.cv    = ($urandom_range(0, 2) != 0);
      v.ctag  = 3'($urandom_range(0, 7));
      v.cval  = $urandom;
      v.ir    = ($urandom_range(0, 4) > 1);
      apply(v);
      #2;
      check_model($sformatf("rnd%0d", c));
      @(posedge clock);
      model_update();
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
